// File: rtl/seg_scan_display.sv
// Scanned multi-digit seven-segment driver: one anode at a time, blanking at the
// start of each slot, per-digit enable/blink, and note loading committed only at frame edges.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_SCANS  = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] notes,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_SCANS - 1);

  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [SW-1:0] scan_q;
  logic          phase_q;
  logic [3:0]    pend_q [NUM_DIGITS];
  logic [3:0]    shad_q [NUM_DIGITS];

  logic                  slot_end;
  logic                  frame_end;
  logic                  visible;
  logic                  lit;
  logic [3:0]            cur_code;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; codes 8..15 are blank.
  function automatic logic [7:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 8'hC6;
      4'd1:    decode = 8'h80;
      4'd2:    decode = 8'h88;
      4'd3:    decode = 8'h82;
      4'd4:    decode = 8'h8E;
      4'd5:    decode = 8'h86;
      4'd6:    decode = 8'hC0;
      4'd7:    decode = 8'h46;
      default: decode = 8'hFF;
    endcase
  endfunction

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Enable and blink act live; only the note codes wait for the frame edge.
  always_comb begin
    cur_code = shad_q[idx_q];
    visible  = digit_en[idx_q] & ~(blink[idx_q] & phase_q);
    lit      = visible && (cnt_q >= BLANK_END);
    an_d     = '1;
    seg_d    = 8'hFF;
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = decode(cur_code);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      scan_q      <= '0;
      phase_q     <= 1'b0;
      seg         <= 8'hFF;
      an          <= '1;
      frame_start <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        pend_q[k] <= 4'hF;
        shad_q[k] <= 4'hF;
      end
    end else begin
      seg         <= seg_d;
      an          <= an_d;
      frame_start <= frame_end;

      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // load is a one-cycle strobe; a strobe on the frame edge bypasses pending.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (load) pend_q[k] <= notes[4*k +: 4];
        if (frame_end) shad_q[k] <= load ? notes[4*k +: 4] : pend_q[k];
      end

      if (frame_end) begin
        if (scan_q == SCAN_LAST) begin
          scan_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          scan_q <= scan_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Time-multiplexed multi-digit seven-segment driver for the FPGA piano.
- Replaces single-digit asynchronous note decode with a registered, scanned driver.
- Shows up to NUM_DIGITS note codes, one digit lit at a time.
- Adds per-digit enable, per-digit blink, inter-digit blanking against ghosting, and frame-synchronous note loading so a digit never tears mid-scan.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes; must be >= 2.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- BLINK_SCANS, 50, full frames per blink half-period; must be >= 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- notes, input, 4*NUM_DIGITS, note code per digit; digit k is notes[4k+3:4k].
- load, input, 1, capture notes into the pending register this cycle.
- digit_en, input, NUM_DIGITS, 1 = digit k may light.
- blink, input, NUM_DIGITS, 1 = digit k blinks.
- seg, output, 8, active-low segments {dp,g,f,e,d,c,b,a}; registered.
- an, output, NUM_DIGITS, active-low anodes; registered.
- frame_start, output, 1, one-cycle pulse when the pending register is committed to the shadow register; registered.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - seg=8'hFF, an=all ones, frame_start=0.
  - cnt=0, idx=0, scan_cnt=0, blink_phase=0.
  - pending and shadow all 4'hF (blank).
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - At the wrap, idx increments; idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle where cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
  - shadow <= (load ? notes : pending).
  - frame_start <= 1 for the next cycle only.
  - scan_cnt increments. When it reaches BLINK_SCANS-1 it wraps to 0 and blink_phase toggles.
- Load:
  - load=1 sets pending <= notes.
  - Last load before a frame boundary wins.
  - Load at the boundary goes straight to shadow.
- Decode of shadow digit idx (active-low):
  - 0 C=8'hC6, 1 B=8'h80, 2 A=8'h88, 3 G=8'h82, 4 F=8'h8E, 5 E=8'h86, 6 D=8'hC0, 7 high C=8'h46 (dp lit).
  - 8..15 blank=8'hFF.
- visible = digit_en[idx] & ~(blink[idx] & blink_phase).
- Output register (1-cycle latency from cnt/idx):
  - If cnt < BLANK_CYCLES or !visible: an <= all ones, seg <= 8'hFF.
  - Otherwise: an <= ~(1<<idx), seg <= decode(shadow[idx]).
- At most one an bit is low in any cycle, always.
- digit_en/blink are sampled live, not frame-synchronous.
- A reset asserted mid-slot returns to the reset state immediately. The first lit digit after release is digit 0, once cnt reaches BLANK_CYCLES.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=1, BLINK_SCANS=2):
1. Reset, digit_en=4'hF, blink=0, load notes=16'h0123 one cycle before the first frame boundary:
   - Before the boundary: all blank.
   - Then per slot: cycle 1 blank, cycles 2..8 lit.
   - Digit sequence: an=1110 seg=82, an=1101 seg=88, an=1011 seg=80, an=0111 seg=C6.
   - frame_start pulses once per 32 cycles.
2. Load notes=16'h7777 mid-frame (idx=1, cnt=3):
   - seg values unchanged until after the next frame boundary.
   - Then all digits show 8'h46.
3. digit_en=4'b0101:
   - an never shows 1101 or 0111; those slots give an=1111, seg=FF.
4. blink=4'b0001:
   - digit 0 lit for 2 frames, blank for 2 frames, repeating.
   - Other digits unaffected.
5. Note code 4'hA on digit 2: slot shows an=1111, seg=FF during the blank cycle, then an=1011, seg=FF.
6. Assert rst_n=0 at idx=2, cnt=5:
   - Same cycle: seg=FF, an=1111.
   - After release: shadow blank, idx=0, frame_start first pulses 32 cycles later.
